// File: rtl/set_dispatch.sv
// Command front-end for the SET circle-membership engine: buffers host commands,
// issues them one at a time to SET, and returns the candidate count with its tag.
module set_dispatch #(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 4,
    parameter int EN_CYCLES = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [23:0]             cmd_central,
    input  logic [11:0]             cmd_radius,
    input  logic [1:0]              cmd_mode,
    input  logic [TAG_W-1:0]        cmd_tag,
    output logic                    set_en,
    output logic [23:0]             set_central,
    output logic [11:0]             set_radius,
    output logic [1:0]              set_mode,
    input  logic                    set_busy,
    input  logic                    set_valid,
    input  logic [7:0]              set_candidate,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [7:0]              res_candidate,
    output logic [TAG_W-1:0]        res_tag,
    output logic [1:0]              res_mode,
    output logic                    res_err,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [1:0]    EN_LAST = 2'(EN_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_t;

    state_t state, state_nxt;

    logic [23:0]      fifo_central [DEPTH];
    logic [11:0]      fifo_radius  [DEPTH];
    logic [1:0]       fifo_mode    [DEPTH];
    logic [TAG_W-1:0] fifo_tag     [DEPTH];

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [TAG_W-1:0] cur_tag;
    logic [1:0]       en_cnt;
    logic [WW-1:0]    wd;
    logic             push;
    logic             pop;
    logic             timeout_hit;

    // No bypass: a full FIFO refuses a push even when a pop happens in the same cycle.
    assign cmd_ready   = (fifo_count != FULL);
    assign push        = cmd_valid && cmd_ready;
    assign pop         = (state == IDLE) && (state_nxt == ISSUE);
    assign timeout_hit = (wd == WD_LAST);
    assign set_en      = (state == ISSUE);
    assign res_valid   = (state == RESULT);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_central[wr_ptr] <= cmd_central;
            fifo_radius[wr_ptr]  <= cmd_radius;
            fifo_mode[wr_ptr]    <= cmd_mode;
            fifo_tag[wr_ptr]     <= cmd_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // set_valid takes priority over a watchdog expiry landing in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fifo_count != '0 && !set_busy) state_nxt = ISSUE;
            ISSUE:   if (en_cnt == EN_LAST) state_nxt = WAIT;
            WAIT:    if (set_valid || timeout_hit) state_nxt = RESULT;
            RESULT:  if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_central   <= '0;
            set_radius    <= '0;
            set_mode      <= '0;
            cur_tag       <= '0;
            en_cnt        <= '0;
            wd            <= '0;
            res_candidate <= '0;
            res_tag       <= '0;
            res_mode      <= '0;
            res_err       <= 1'b0;
        end else begin
            if (pop) begin
                set_central <= fifo_central[rd_ptr];
                set_radius  <= fifo_radius[rd_ptr];
                set_mode    <= fifo_mode[rd_ptr];
                cur_tag     <= fifo_tag[rd_ptr];
                en_cnt      <= '0;
                wd          <= '0;
            end
            if (state == ISSUE) begin
                en_cnt <= en_cnt + 2'd1;
                wd     <= wd + WW'(1);
            end
            if (state == WAIT) begin
                wd <= wd + WW'(1);
                if (set_valid) begin
                    res_candidate <= set_candidate;
                    res_tag       <= cur_tag;
                    res_mode      <= set_mode;
                    res_err       <= 1'b0;
                end else if (timeout_hit) begin
                    res_candidate <= '0;
                    res_tag       <= cur_tag;
                    res_mode      <= set_mode;
                    res_err       <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_set_dispatch.sv
// Directed-plus-random bench for set_dispatch; a command queue models the FIFO
// and each result is predicted from the command that the queue says is in flight.
module tb_set_dispatch;

    localparam int DEPTH     = 4;
    localparam int TAG_W     = 4;
    localparam int EN_CYCLES = 2;
    localparam int TIMEOUT   = 1024;

    typedef struct {
        logic [23:0]      central;
        logic [11:0]      radius;
        logic [1:0]       mode;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   cmd_valid = 1'b0;
    logic                   cmd_ready;
    logic [23:0]            cmd_central = '0;
    logic [11:0]            cmd_radius = '0;
    logic [1:0]             cmd_mode = '0;
    logic [TAG_W-1:0]       cmd_tag = '0;
    logic                   set_en;
    logic [23:0]            set_central;
    logic [11:0]            set_radius;
    logic [1:0]             set_mode;
    logic                   set_busy = 1'b0;
    logic                   set_valid = 1'b0;
    logic [7:0]             set_candidate = '0;
    logic                   res_valid;
    logic                   res_ready = 1'b1;
    logic [7:0]             res_candidate;
    logic [TAG_W-1:0]       res_tag;
    logic [1:0]             res_mode;
    logic                   res_err;
    logic [$clog2(DEPTH):0] fifo_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    cmd_t model_q[$];

    set_dispatch #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .EN_CYCLES(EN_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_central(cmd_central), .cmd_radius(cmd_radius),
        .cmd_mode(cmd_mode), .cmd_tag(cmd_tag),
        .set_en(set_en), .set_central(set_central), .set_radius(set_radius),
        .set_mode(set_mode), .set_busy(set_busy), .set_valid(set_valid),
        .set_candidate(set_candidate),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_candidate(res_candidate), .res_tag(res_tag), .res_mode(res_mode),
        .res_err(res_err), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.central = 24'($urandom());
        c.radius  = 12'($urandom());
        c.mode    = 2'($urandom_range(3, 0));
        c.tag     = TAG_W'($urandom());
        return c;
    endfunction

    task automatic drive_cmd(input cmd_t c);
        cmd_valid   = 1'b1;
        cmd_central = c.central;
        cmd_radius  = c.radius;
        cmd_mode    = c.mode;
        cmd_tag     = c.tag;
    endtask

    // One accepted push; the bench only calls this when it knows the FIFO has room.
    task automatic apply_stimulus(input cmd_t c);
        check_output("push_ready", cmd_ready, 1);
        drive_cmd(c);
        model_q.push_back(c);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Act as SET for the next issued command and check the returned result.
    task automatic serve(input logic [7:0] cand, input int pre_en, output int waited);
        cmd_t head;
        int   n;
        waited = 0;
        while (!set_en && waited < 200) begin
            tick();
            waited++;
        end
        check_output("issue_seen", set_en, 1);
        head = model_q.pop_front();
        check_output("set_central", set_central, head.central);
        check_output("set_radius", set_radius, head.radius);
        check_output("set_mode", set_mode, head.mode);
        n = pre_en;
        while (set_en && n < 8) begin
            n++;
            tick();
        end
        check_output("en_cycles", n, EN_CYCLES);
        set_valid     = 1'b1;
        set_candidate = cand;
        tick();
        set_valid     = 1'b0;
        set_candidate = 8'($urandom());
        check_output("res_valid", res_valid, 1);
        check_output("res_candidate", res_candidate, cand);
        check_output("res_tag", res_tag, head.tag);
        check_output("res_mode", res_mode, head.mode);
        check_output("res_err", res_err, 0);
        check_output("op_stable", set_central, head.central);
        if (res_ready) begin
            tick();
            check_output("res_handoff", res_valid, 0);
        end
    endtask

    initial begin
        cmd_t c, c5;
        int   k;
        logic [7:0] cand;

        // Reset state
        tick();
        tick();
        check_output("rst_cmd_ready", cmd_ready, 1);
        check_output("rst_set_en", set_en, 0);
        check_output("rst_set_central", set_central, 0);
        check_output("rst_res_valid", res_valid, 0);
        check_output("rst_fifo_count", fifo_count, 0);
        rst = 1'b1;
        tick();

        // Single command, fixed operands, latency from push to set_en
        c.central = 24'h444444;
        c.radius  = 12'h300;
        c.mode    = 2'd0;
        c.tag     = 4'd5;
        apply_stimulus(c);
        check_output("t1_no_en_yet", set_en, 0);
        check_output("t1_count", fifo_count, 1);
        serve(8'd29, 0, k);
        check_output("t1_latency", k, 1);

        // Fill the FIFO while SET is busy, then a fifth push waits for the first pop
        set_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) apply_stimulus(rand_cmd());
        check_output("t2_full_ready", cmd_ready, 0);
        check_output("t2_full_count", fifo_count, DEPTH);
        tick();
        check_output("t2_busy_no_en", set_en, 0);
        c5 = rand_cmd();
        drive_cmd(c5);
        set_busy = 1'b0;
        tick();
        check_output("t2_pop_en", set_en, 1);
        check_output("t2_pop_count", fifo_count, DEPTH - 1);
        check_output("t2_pop_ready", cmd_ready, 1);
        model_q.push_back(c5);
        tick();
        cmd_valid = 1'b0;
        check_output("t2_refill_count", fifo_count, DEPTH);
        serve(8'($urandom()), 1, k);
        for (int i = 0; i < DEPTH; i++) serve(8'($urandom()), 0, k);
        check_output("t2_drained", fifo_count, 0);

        // Result back-pressure holds everything and blocks the next issue
        res_ready = 1'b0;
        apply_stimulus(rand_cmd());
        apply_stimulus(rand_cmd());
        cand = 8'($urandom());
        c = model_q[0];
        serve(cand, 0, k);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_output("t3_hold_valid", res_valid, 1);
            check_output("t3_hold_cand", res_candidate, cand);
            check_output("t3_hold_tag", res_tag, c.tag);
            check_output("t3_hold_no_en", set_en, 0);
        end
        res_ready = 1'b1;
        tick();
        check_output("t3_release", res_valid, 0);
        check_output("t3_idle_en", set_en, 0);
        tick();
        check_output("t3_next_issue", set_en, 1);
        serve(8'($urandom()), 0, k);

        // Watchdog expiry, then a late set_valid must be discarded
        apply_stimulus(rand_cmd());
        c = model_q.pop_front();
        k = 0;
        while (!set_en && k < 20) begin
            tick();
            k++;
        end
        check_output("t4_issue", set_en, 1);
        k = 0;
        while (!res_valid && k < TIMEOUT + 50) begin
            tick();
            k++;
        end
        check_output("t4_timeout_cycles", k, TIMEOUT);
        check_output("t4_err", res_err, 1);
        check_output("t4_cand_zero", res_candidate, 0);
        check_output("t4_op_stable", set_central, c.central);
        set_valid     = 1'b1;
        set_candidate = 8'hA5;
        tick();
        set_valid = 1'b0;
        check_output("t4_late_valid", res_valid, 0);
        check_output("t4_late_cand", res_candidate, 0);
        tick();
        check_output("t4_late_no_res", res_valid, 0);
        check_output("t4_late_no_en", set_en, 0);

        // set_busy blocks issue; set_valid on the timeout cycle wins
        set_busy = 1'b1;
        apply_stimulus(rand_cmd());
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("t5_busy_no_en", set_en, 0);
        end
        set_busy = 1'b0;
        serve(8'($urandom()), 0, k);
        apply_stimulus(rand_cmd());
        c = model_q.pop_front();
        k = 0;
        while (!set_en && k < 20) begin
            tick();
            k++;
        end
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check_output("t5_not_yet", res_valid, 0);
        cand          = 8'($urandom());
        set_valid     = 1'b1;
        set_candidate = cand;
        tick();
        set_valid = 1'b0;
        check_output("t5_race_valid", res_valid, 1);
        check_output("t5_race_err", res_err, 0);
        check_output("t5_race_cand", res_candidate, cand);
        check_output("t5_race_tag", res_tag, c.tag);
        tick();

        // Asynchronous reset while waiting on SET
        apply_stimulus(rand_cmd());
        apply_stimulus(rand_cmd());
        k = 0;
        while (!set_en && k < 20) begin
            tick();
            k++;
        end
        while (set_en && k < 40) begin
            tick();
            k++;
        end
        #2;
        rst = 1'b0;
        #1;
        check_output("t6_cmd_ready", cmd_ready, 1);
        check_output("t6_set_en", set_en, 0);
        check_output("t6_set_central", set_central, 0);
        check_output("t6_set_radius", set_radius, 0);
        check_output("t6_set_mode", set_mode, 0);
        check_output("t6_res_valid", res_valid, 0);
        check_output("t6_res_cand", res_candidate, 0);
        check_output("t6_res_tag", res_tag, 0);
        check_output("t6_res_mode", res_mode, 0);
        check_output("t6_res_err", res_err, 0);
        check_output("t6_count", fifo_count, 0);
        model_q.delete();
        #3;
        rst = 1'b1;
        tick();
        check_output("t6_post_count", fifo_count, 0);
        tick();
        check_output("t6_post_no_en", set_en, 0);
        check_output("t6_post_no_res", res_valid, 0);

        $display("[TB] stimulus complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
